// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory: FSM state encodings and the fill-word default.
// PROG_MEM_CLEAR_EN adds the CLEAR state used to wipe memory before each download.
package prog_mem_pkg;

  localparam logic [27:0] PM_FILL_DEFAULT = 28'h000_0000;

`ifdef PROG_MEM_CLEAR_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_READY = 2'd3
  } pm_state_e;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd2,
    ST_READY = 2'd3
  } pm_state_e;
`endif

  // A fetch address is usable only when every bit above the memory index is zero.
  function automatic logic pm_in_range(input logic [15:0] addr, input int unsigned aw);
    return ((addr >> aw) == 16'h0000);
  endfunction

endpackage

// File: rtl/prog_mem_if.sv
// CPU fetch port and program-download handshake of the program memory.
interface prog_mem_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 8
);
  logic [15:0]           iFetchAddress;
  logic [DATA_WIDTH-1:0] oInstruction;
  logic                  oInstrValid;
  logic                  oCpuHold;
  logic                  iLoadStart;
  logic [DATA_WIDTH-1:0] iLoadData;
  logic                  iLoadValid;
  logic                  iLoadLast;
  logic                  oLoadReady;
  logic                  oLoadDone;
  logic [ADDR_WIDTH:0]   oLoadCount;
  logic                  oLoadError;

  modport master (
    output iFetchAddress, iLoadStart, iLoadData, iLoadValid, iLoadLast,
    input  oInstruction, oInstrValid, oCpuHold, oLoadReady, oLoadDone, oLoadCount, oLoadError
  );

  modport slave (
    input  iFetchAddress, iLoadStart, iLoadData, iLoadValid, iLoadLast,
    output oInstruction, oInstrValid, oCpuHold, oLoadReady, oLoadDone, oLoadCount, oLoadError
  );
endinterface

// File: rtl/prog_mem_ram.sv
// Simple dual-port RAM: synchronous write, registered read, contents not reset.
module prog_mem_ram #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_r
);
  logic [DATA_WIDTH-1:0] mem_r [0:(32'd1 << ADDR_WIDTH)-1];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    rd_data_r <= mem_r[rd_addr];
  end
endmodule

// File: rtl/prog_mem.sv
// Downloadable CPU program memory: load FSM, overflow tracking and registered fetch path.
// Define PROG_MEM_CLEAR_EN to wipe the whole memory to FILL_WORD before every download.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 28,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(PM_FILL_DEFAULT)
) (
  input  logic      Clock,
  input  logic      Reset,
  prog_mem_if.slave bus
);
  localparam int                  DEPTH     = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(32'd1);
  localparam logic [ADDR_WIDTH:0] CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
`ifdef PROG_MEM_CLEAR_EN
  localparam pm_state_e           START_ST  = ST_CLEAR;
  localparam logic [ADDR_WIDTH-1:0] CLR_ONE = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] CLR_END = {ADDR_WIDTH{1'b1}};
`else
  localparam pm_state_e           START_ST  = ST_LOAD;
`endif

  pm_state_e             state_r, state_s;
  logic [ADDR_WIDTH:0]   count_r, count_s;
  logic                  err_r, err_s;
  logic                  ready_r, done_r, hold_r, fetch_ok_r;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
`ifdef PROG_MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_r, clr_s;
`endif

  // next-state, download counter, error flag and RAM write request
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    err_s     = err_r;
    wr_en_s   = 1'b0;
    wr_addr_s = count_r[ADDR_WIDTH-1:0];
    wr_data_s = bus.iLoadData;
`ifdef PROG_MEM_CLEAR_EN
    clr_s     = clr_r;
`endif
    case (state_r)
      ST_EMPTY, ST_READY: begin
        if (bus.iLoadStart) begin
          state_s = START_ST;
          count_s = CNT_ZERO;
          err_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
`ifdef PROG_MEM_CLEAR_EN
      ST_CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_r;
        wr_data_s = FILL_WORD;
        clr_s     = clr_r + CLR_ONE;
        if (clr_r == CLR_END) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_CLEAR;
        end
      end
`endif
      ST_LOAD: begin
        // a restart outranks a word offered in the same cycle
        if (bus.iLoadStart) begin
          state_s = START_ST;
          count_s = CNT_ZERO;
          err_s   = 1'b0;
        end else if (bus.iLoadValid) begin
          if (count_r == DEPTH_CNT) begin
            err_s = 1'b1;
          end else begin
            wr_en_s = 1'b1;
            count_s = count_r + CNT_ONE;
          end
          if (bus.iLoadLast) begin
            state_s = ST_READY;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // state and registered status outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_EMPTY;
      count_r    <= CNT_ZERO;
      err_r      <= 1'b0;
      ready_r    <= 1'b0;
      done_r     <= 1'b0;
      hold_r     <= 1'b1;
      fetch_ok_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      err_r      <= err_s;
      ready_r    <= (state_s == ST_LOAD);
      done_r     <= (state_s == ST_READY) && (state_r != ST_READY);
      hold_r     <= (state_s != ST_READY);
      fetch_ok_r <= (state_r == ST_READY) && pm_in_range(bus.iFetchAddress, ADDR_WIDTH);
    end
  end

`ifdef PROG_MEM_CLEAR_EN
  // clear sweep address; wraps back to zero at the end of every sweep
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      clr_r <= clr_s;
    end
  end
`endif

  prog_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (Clock),
    .wr_en     (wr_en_s),
    .wr_addr   (wr_addr_s),
    .wr_data   (wr_data_s),
    .rd_addr   (bus.iFetchAddress[ADDR_WIDTH-1:0]),
    .rd_data_r (rd_data_s)
  );

  assign bus.oInstruction = fetch_ok_r ? rd_data_s : FILL_WORD;
  assign bus.oInstrValid  = fetch_ok_r;
  assign bus.oCpuHold     = hold_r;
  assign bus.oLoadReady   = ready_r;
  assign bus.oLoadDone    = done_r;
  assign bus.oLoadCount   = count_r;
  assign bus.oLoadError   = err_r;
endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: 256-word instance for main traffic, 4-word instance for overflow.
module tb_prog_mem;
  localparam logic [27:0] FILL8 = 28'hFACE0FF;
  localparam logic [27:0] FILL2 = 28'h0123456;
`ifdef PROG_MEM_CLEAR_EN
  localparam int WAIT8 = 256;
  localparam int WAIT2 = 4;
  localparam bit CLR   = 1'b1;
`else
  localparam int WAIT8 = 0;
  localparam int WAIT2 = 0;
  localparam bit CLR   = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [27:0] mmem [256];
  bit          mknown [256];
  int          mcount;
  bit          merr;

  prog_mem_if #(.DATA_WIDTH(28), .ADDR_WIDTH(8)) bus8 ();
  prog_mem_if #(.DATA_WIDTH(28), .ADDR_WIDTH(2)) bus2 ();

  prog_mem #(.DATA_WIDTH(28), .ADDR_WIDTH(8), .FILL_WORD(FILL8)) dut8 (
    .Clock (Clock), .Reset (Reset), .bus (bus8));
  prog_mem #(.DATA_WIDTH(28), .ADDR_WIDTH(2), .FILL_WORD(FILL2)) dut2 (
    .Clock (Clock), .Reset (Reset), .bus (bus2));

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_restart();
    mcount = 0;
    merr   = 1'b0;
    if (CLR) begin
      for (int i = 0; i < 256; i++) begin
        mmem[i]   = FILL8;
        mknown[i] = 1'b1;
      end
    end
  endtask

  // waits for the load window; a start pulse mid-wait must be ignored while clearing
  task automatic wait_ready8(output int n);
    n = 0;
    while (bus8.oLoadReady !== 1'b1 && n < 1000) begin
      bus8.iLoadStart = (n == 10);
      tick();
      n++;
    end
    bus8.iLoadStart = 1'b0;
  endtask

  task automatic start8(input bit with_valid, output int n);
    bus8.iLoadStart = 1'b1;
    bus8.iLoadValid = with_valid;
    bus8.iLoadLast  = with_valid;
    bus8.iLoadData  = 28'($urandom);
    tick();
    bus8.iLoadStart = 1'b0;
    bus8.iLoadValid = 1'b0;
    bus8.iLoadLast  = 1'b0;
    model_restart();
    wait_ready8(n);
  endtask

  task automatic load_word8(input logic [27:0] w, input bit last);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      bus8.iLoadValid = 1'b0;
      bus8.iLoadLast  = 1'b1;
      bus8.iLoadData  = 28'($urandom);
      tick();
    end
    bus8.iLoadValid = 1'b1;
    bus8.iLoadLast  = last;
    bus8.iLoadData  = w;
    tick();
    bus8.iLoadValid = 1'b0;
    bus8.iLoadLast  = 1'b0;
    if (mcount < 256) begin
      mmem[mcount]   = w;
      mknown[mcount] = 1'b1;
      mcount++;
    end else begin
      merr = 1'b1;
    end
  endtask

  task automatic fetch8(input logic [15:0] a);
    bus8.iFetchAddress = a;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({bus8.oInstruction, bus8.oInstrValid, bus8.oCpuHold, bus8.oLoadReady, bus8.oLoadDone,
         bus8.oLoadCount, bus8.oLoadError} !== {FILL8, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset8: got instr=%h v=%b hold=%b rdy=%b done=%b cnt=%0d err=%b expected %h 0 1 0 0 0 0",
               bus8.oInstruction, bus8.oInstrValid, bus8.oCpuHold, bus8.oLoadReady, bus8.oLoadDone,
               bus8.oLoadCount, bus8.oLoadError, FILL8);
    end
    checks++;
    if ({bus2.oInstruction, bus2.oInstrValid, bus2.oCpuHold, bus2.oLoadReady, bus2.oLoadDone,
         bus2.oLoadCount, bus2.oLoadError} !== {FILL2, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset2: got instr=%h v=%b hold=%b cnt=%0d expected %h 0 1 0",
               bus2.oInstruction, bus2.oInstrValid, bus2.oCpuHold, bus2.oLoadCount, FILL2);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    start8(1'b0, n);
    checks++;
    if (n != WAIT8) begin
      errors++;
      $display("FAIL basic_wait: got %0d cycles expected %0d", n, WAIT8);
    end
    load_word8(28'hA, 1'b0);
    load_word8(28'hB, 1'b0);
    load_word8(28'hC, 1'b1);
    checks++;
    if ({bus8.oLoadDone, bus8.oCpuHold, bus8.oLoadCount} !== {1'b1, 1'b0, 9'd3}) begin
      errors++;
      $display("FAIL basic_done: got done=%b hold=%b cnt=%0d expected 1 0 3",
               bus8.oLoadDone, bus8.oCpuHold, bus8.oLoadCount);
    end
    fetch8(16'd1);
    checks++;
    if ({bus8.oLoadDone, bus8.oInstrValid, bus8.oInstruction} !== {1'b0, 1'b1, 28'hB}) begin
      errors++;
      $display("FAIL basic_fetch: got done=%b v=%b instr=%h expected 0 1 000000b",
               bus8.oLoadDone, bus8.oInstrValid, bus8.oInstruction);
    end
  endtask

  task automatic test_random_load();
    int n, len, a;
    repeat (3) begin
      start8(1'b0, n);
      checks++;
      if (n != WAIT8 || bus8.oLoadCount !== 9'd0) begin
        errors++;
        $display("FAIL rand_start: got wait=%0d cnt=%0d expected %0d 0", n, bus8.oLoadCount, WAIT8);
      end
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) load_word8(28'($urandom), (i == len - 1));
      checks++;
      if ({bus8.oLoadDone, bus8.oCpuHold, bus8.oLoadError, bus8.oLoadCount} !==
          {1'b1, 1'b0, merr, 9'(mcount)}) begin
        errors++;
        $display("FAIL rand_done: got done=%b hold=%b err=%b cnt=%0d expected 1 0 %b %0d",
                 bus8.oLoadDone, bus8.oCpuHold, bus8.oLoadError, bus8.oLoadCount, merr, mcount);
      end
      repeat (6) begin
        a = $urandom_range(0, len - 1);
        fetch8(16'(a));
        checks++;
        if ({bus8.oInstrValid, bus8.oInstruction} !== {1'b1, mmem[a]}) begin
          errors++;
          $display("FAIL rand_fetch[%0d]: got v=%b %h expected 1 %h",
                   a, bus8.oInstrValid, bus8.oInstruction, mmem[a]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 16'h0100 : 16'($urandom_range(256, 65535));
      fetch8(a);
      checks++;
      if ({bus8.oInstrValid, bus8.oInstruction} !== {1'b0, FILL8}) begin
        errors++;
        $display("FAIL oor_fetch[%h]: got v=%b %h expected 0 %h", a, bus8.oInstrValid, bus8.oInstruction, FILL8);
      end
    end
    fetch8(16'd0);
    checks++;
    if ({bus8.oInstrValid, bus8.oInstruction} !== {1'b1, mmem[0]}) begin
      errors++;
      $display("FAIL oor_recover: got v=%b %h expected 1 %h", bus8.oInstrValid, bus8.oInstruction, mmem[0]);
    end
  endtask

  task automatic test_overflow();
    logic [27:0] w [5];
    int n;
    bus2.iLoadStart = 1'b1;
    tick();
    bus2.iLoadStart = 1'b0;
    n = 0;
    while (bus2.oLoadReady !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != WAIT2) begin
      errors++;
      $display("FAIL ovf_wait: got %0d cycles expected %0d", n, WAIT2);
    end
    for (int i = 0; i < 5; i++) begin
      w[i] = 28'($urandom);
      bus2.iLoadValid = 1'b1;
      bus2.iLoadData  = w[i];
      bus2.iLoadLast  = (i == 4);
      tick();
      if (i == 3) begin
        checks++;
        if ({bus2.oLoadCount, bus2.oLoadError} !== {3'd4, 1'b0}) begin
          errors++;
          $display("FAIL ovf_full: got cnt=%0d err=%b expected 4 0", bus2.oLoadCount, bus2.oLoadError);
        end
      end
    end
    bus2.iLoadValid = 1'b0;
    bus2.iLoadLast  = 1'b0;
    checks++;
    if ({bus2.oLoadDone, bus2.oLoadError, bus2.oLoadCount} !== {1'b1, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL ovf_done: got done=%b err=%b cnt=%0d expected 1 1 4",
               bus2.oLoadDone, bus2.oLoadError, bus2.oLoadCount);
    end
    bus2.iFetchAddress = 16'd3;
    tick();
    checks++;
    if ({bus2.oInstrValid, bus2.oInstruction} !== {1'b1, w[3]}) begin
      errors++;
      $display("FAIL ovf_addr3: got v=%b %h expected 1 %h", bus2.oInstrValid, bus2.oInstruction, w[3]);
    end
    bus2.iFetchAddress = 16'd4;
    tick();
    checks++;
    if ({bus2.oInstrValid, bus2.oInstruction, bus2.oLoadError} !== {1'b0, FILL2, 1'b1}) begin
      errors++;
      $display("FAIL ovf_addr4: got v=%b %h err=%b expected 0 %h 1",
               bus2.oInstrValid, bus2.oInstruction, bus2.oLoadError, FILL2);
    end
    bus2.iLoadStart = 1'b1;
    tick();
    bus2.iLoadStart = 1'b0;
    checks++;
    if ({bus2.oLoadError, bus2.oLoadCount, bus2.oCpuHold} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_restart: got err=%b cnt=%0d hold=%b expected 0 0 1",
               bus2.oLoadError, bus2.oLoadCount, bus2.oCpuHold);
    end
  endtask

  task automatic test_start_priority();
    int n, exp_wait;
    bus8.iFetchAddress = 16'd0;
    bus8.iLoadStart = 1'b1;
    bus8.iLoadValid = 1'b1;
    bus8.iLoadLast  = 1'b1;
    bus8.iLoadData  = 28'($urandom);
    tick();
    bus8.iLoadStart = 1'b0;
    bus8.iLoadValid = 1'b0;
    bus8.iLoadLast  = 1'b0;
    model_restart();
    checks++;
    if ({bus8.oCpuHold, bus8.oLoadCount, bus8.oLoadDone} !== {1'b1, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL prio_hold: got hold=%b cnt=%0d done=%b expected 1 0 0",
               bus8.oCpuHold, bus8.oLoadCount, bus8.oLoadDone);
    end
    tick();
    checks++;
    if ({bus8.oInstrValid, bus8.oInstruction} !== {1'b0, FILL8}) begin
      errors++;
      $display("FAIL prio_fill: got v=%b %h expected 0 %h", bus8.oInstrValid, bus8.oInstruction, FILL8);
    end
    wait_ready8(n);
    exp_wait = (WAIT8 > 0) ? WAIT8 - 1 : 0;
    checks++;
    if (n != exp_wait) begin
      errors++;
      $display("FAIL prio_wait: got %0d cycles expected %0d", n, exp_wait);
    end
    load_word8(28'($urandom), 1'b0);
    load_word8(28'($urandom), 1'b0);
    start8(1'b1, n);
    checks++;
    if (n != WAIT8 || bus8.oLoadCount !== 9'd0) begin
      errors++;
      $display("FAIL prio_load_restart: got wait=%0d cnt=%0d expected %0d 0", n, bus8.oLoadCount, WAIT8);
    end
    load_word8(28'($urandom), 1'b1);
    for (int a = 0; a < 3; a++) begin
      fetch8(16'(a));
      if (mknown[a]) begin
        checks++;
        if ({bus8.oInstrValid, bus8.oInstruction} !== {1'b1, mmem[a]}) begin
          errors++;
          $display("FAIL prio_fetch[%0d]: got v=%b %h expected 1 %h",
                   a, bus8.oInstrValid, bus8.oInstruction, mmem[a]);
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    int n;
    start8(1'b0, n);
    load_word8(28'($urandom), 1'b0);
    load_word8(28'($urandom), 1'b0);
    checks++;
    if (bus8.oLoadCount !== 9'd2) begin
      errors++;
      $display("FAIL mid_count: got %0d expected 2", bus8.oLoadCount);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({bus8.oInstruction, bus8.oInstrValid, bus8.oCpuHold, bus8.oLoadReady, bus8.oLoadDone,
         bus8.oLoadCount, bus8.oLoadError} !== {FILL8, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got instr=%h v=%b hold=%b rdy=%b done=%b cnt=%0d err=%b",
               bus8.oInstruction, bus8.oInstrValid, bus8.oCpuHold, bus8.oLoadReady, bus8.oLoadDone,
               bus8.oLoadCount, bus8.oLoadError);
    end
    tick();
    Reset = 1'b1;
    mcount = 0;
    merr   = 1'b0;
    bus8.iLoadValid    = 1'b1;
    bus8.iLoadData     = 28'($urandom);
    bus8.iFetchAddress = 16'd0;
    tick();
    tick();
    bus8.iLoadValid = 1'b0;
    checks++;
    if ({bus8.oLoadCount, bus8.oLoadReady, bus8.oCpuHold, bus8.oInstrValid, bus8.oInstruction} !==
        {9'd0, 1'b0, 1'b1, 1'b0, FILL8}) begin
      errors++;
      $display("FAIL mid_empty: got cnt=%0d rdy=%b hold=%b v=%b %h expected 0 0 1 0 %h",
               bus8.oLoadCount, bus8.oLoadReady, bus8.oCpuHold, bus8.oInstrValid, bus8.oInstruction, FILL8);
    end
  endtask

  task automatic test_reload();
    logic [27:0] w [3];
    logic [27:0] v [2];
    logic [27:0] exp2;
    int n;
    start8(1'b0, n);
    for (int i = 0; i < 3; i++) begin
      w[i] = 28'($urandom);
      load_word8(w[i], (i == 2));
    end
    start8(1'b0, n);
    for (int i = 0; i < 2; i++) begin
      v[i] = 28'($urandom);
      load_word8(v[i], (i == 1));
    end
    exp2 = CLR ? FILL8 : w[2];
    fetch8(16'd2);
    checks++;
    if ({bus8.oInstrValid, bus8.oInstruction} !== {1'b1, exp2}) begin
      errors++;
      $display("FAIL reload_addr2: got v=%b %h expected 1 %h", bus8.oInstrValid, bus8.oInstruction, exp2);
    end
    for (int a = 0; a < 2; a++) begin
      fetch8(16'(a));
      checks++;
      if ({bus8.oInstrValid, bus8.oInstruction} !== {1'b1, v[a]}) begin
        errors++;
        $display("FAIL reload_addr%0d: got v=%b %h expected 1 %h", a, bus8.oInstrValid, bus8.oInstruction, v[a]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mknown[i] = 1'b0;
    mcount = 0;
    merr   = 1'b0;
    bus8.iFetchAddress = 16'd0; bus8.iLoadStart = 1'b0; bus8.iLoadData = 28'd0;
    bus8.iLoadValid = 1'b0; bus8.iLoadLast = 1'b0;
    bus2.iFetchAddress = 16'd0; bus2.iLoadStart = 1'b0; bus2.iLoadData = 28'd0;
    bus2.iLoadValid = 1'b0; bus2.iLoadLast = 1'b0;
    test_reset();
    test_basic();
    test_random_load();
    test_out_of_range();
    test_overflow();
    test_start_priority();
    test_reset_midload();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 28, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning log2 of depth; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter FILL_WORD, default 0, meaning word returned for unwritten, cleared, out-of-range or held fetches.
REQ-004 SHALL provide these ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-low.
- iFetchAddress  in  16  CPU program-counter address.
- oInstruction  out  DATA_WIDTH  fetched word, registered.
- oInstrValid  out  1  oInstruction is from loaded memory.
- oCpuHold  out  1  CPU must stall while high.
- iLoadStart  in  1  one-cycle pulse that begins a program download.
- iLoadData  in  DATA_WIDTH  download word.
- iLoadValid  in  1  iLoadData is valid.
- iLoadLast  in  1  qualifies the final word, sampled with iLoadValid.
- oLoadReady  out  1  block accepts a word this cycle.
- oLoadDone  out  1  one-cycle pulse when a download completes.
- oLoadCount  out  ADDR_WIDTH+1  words written in the current or last download.
- oLoadError  out  1  sticky overflow flag.

Function
REQ-005 SHALL implement the FSM EMPTY -> (iLoadStart) CLEAR or LOAD; CLEAR -> (after DEPTH cycles) LOAD; LOAD -> (accepted word with iLoadLast) READY; READY -> (iLoadStart) CLEAR or LOAD.
REQ-006 SHALL accept a word only when iLoadValid and oLoadReady are both high; oLoadReady SHALL be high only in LOAD.
REQ-007 SHALL write each accepted word to address oLoadCount, then increment oLoadCount; writes start at address 0.
REQ-008 SHALL, in CLEAR, write FILL_WORD to one address per cycle, 0 to DEPTH-1, with oLoadReady low.
REQ-009 SHALL, when a word is accepted with oLoadCount == DEPTH, drop the word, set oLoadError, and continue in LOAD until iLoadLast.
REQ-010 SHALL pulse oLoadDone for exactly one cycle on entry to READY.
REQ-011 SHALL drive oCpuHold high in EMPTY, CLEAR and LOAD, and low only in READY.
REQ-012 SHALL, in READY, register mem[iFetchAddress] into oInstruction with 1-cycle latency and oInstrValid=1.
REQ-013 SHALL, in READY, return FILL_WORD with oInstrValid=0 when iFetchAddress >= DEPTH (upper bits nonzero).
REQ-014 SHALL, when oCpuHold is high, register FILL_WORD and oInstrValid=0.
REQ-015 SHALL, on iLoadStart during LOAD, restart: oLoadCount=0, oLoadError=0, next state CLEAR or LOAD per REQ-022.
REQ-016 SHALL ignore iLoadStart during CLEAR.
REQ-017 SHALL, when iLoadStart and iLoadValid are high in the same cycle, give iLoadStart priority; that data is not written.
REQ-018 SHALL ignore iLoadValid outside LOAD.
REQ-019 SHALL clear oLoadError only on an accepted iLoadStart or on reset.

Reset
REQ-020 SHALL, on Reset low, asynchronously set: state=EMPTY, oInstruction=FILL_WORD, oInstrValid=0, oCpuHold=1, oLoadReady=0, oLoadDone=0, oLoadCount=0, oLoadError=0.
REQ-021 SHALL NOT reset memory contents; mid-download reset aborts the download, and the next iLoadStart is required before fetch resumes.

Configuration
REQ-022 SHALL honour macro PROG_MEM_CLEAR_EN: defined, iLoadStart enters CLEAR and then LOAD (DEPTH-cycle clear); undefined, iLoadStart enters LOAD directly, no CLEAR state exists, and unwritten words keep prior contents.

Structure
REQ-023 SHALL take opcode/register encodings from the shared Definitions.v and define FSM state encodings and the FILL_WORD default in a shared prog_mem_pkg include.
REQ-024 SHALL instantiate one sub-module prog_mem_ram: simple dual-port, synchronous write, registered read, DATA_WIDTH x DEPTH.

Verification
REQ-025 SHALL cover: reset, then iLoadStart and 3 words 0xA,0xB,0xC (last on 0xC) -> oLoadDone pulse, oLoadCount=3, fetch address 1 returns 0xB one cycle later, oInstrValid=1.
REQ-026 SHALL cover: ADDR_WIDTH=2, 5 words loaded -> oLoadError=1, oLoadCount=4, address 3 holds the 4th word.
REQ-027 SHALL cover: fetch address 0x0100 with ADDR_WIDTH=8 -> FILL_WORD, oInstrValid=0.
REQ-028 SHALL cover: iLoadStart and iLoadValid in the same READY cycle -> word not written; oCpuHold rises next cycle.
REQ-029 SHALL cover: Reset low during LOAD at count 2 -> all outputs at reset values; state EMPTY.
REQ-030 SHALL cover: PROG_MEM_CLEAR_EN defined, 2-word reload over a 3-word program -> address 2 reads FILL_WORD; PROG_MEM_CLEAR_EN undefined -> address 2 keeps the old word.
